wshb_arbiter: RTL and testbench
===============================

// Module: wshb_arbiter
// PURPOSE
//  Registered two-requester Wishbone arbiter. It shares the single SDRAM Wishbone master port
//  between the test-pattern writer (mire) and the VGA frame reader (vga).
//  Ownership is held in a state register and changes only at transaction boundaries.
//  An optional beat limit on mire bounds VGA read latency, which protects the VGA pixel FIFO.
// PARAMETERS
//  VGA_PRIO        1   1: vga wins simultaneous requests in IDLE; 0: round-robin on last owner
//  MIRE_MAX_BEATS  16  acks mire may receive per grant while vga waits; 0 = no preemption
// PORTS
//  clk            in   1    system clock (same clock as wshb_ifm.clk)
//  rst            in   1    asynchronous reset, active-high
//  wshb_ifs_mire  slv  if   wshb_if.slave, mire requester
//  wshb_ifs_vga   slv  if   wshb_if.slave, vga requester
//  wshb_ifm       mst  if   wshb_if.master, toward SDRAM controller
//  grant          out  2    one-hot owner {vga,mire}; 2'b00 = IDLE (debug/status)
// BEHAVIOUR
//  Reset (async, immediate on rst=1):
//   - state=IDLE, last_owner=VGA (mire wins the first round-robin tie), beat_cnt=0
//   - grant=0; wshb_ifm.cyc/stb/we=0; adr/sel/cti/bte/dat_ms=0; both slave acks=0
//  FSM states: IDLE, MIRE, VGA. Next state is registered on posedge clk.
//  Transitions out of IDLE:
//   - only mire.cyc -> MIRE; only vga.cyc -> VGA
//   - both requesting: VGA_PRIO=1 -> VGA; VGA_PRIO=0 -> the non-last_owner
//  Transitions out of MIRE/VGA:
//   - owner.cyc=0 -> re-arbitrate like IDLE, excluding the owner, so there is no dead cycle
//     when the other side waits; no request -> IDLE
//  Preemption (MIRE only, MIRE_MAX_BEATS>0):
//   - preempt when all hold on one cycle: mire ack, beat_cnt+1 >= MIRE_MAX_BEATS, vga.cyc=1,
//     and mire.cti in {3'b000, 3'b111}
//   - mire is never preempted mid incrementing burst
//   - preempted mire keeps cyc/stb high and waits without ack; it is re-granted when vga
//     drops cyc
//  Muxing (combinational from the state register only, never from cyc):
//   - wshb_ifm.{cyc,stb,we,adr,sel,cti,bte,dat_ms} = owner's signals; all 0 in IDLE
//   - wshb_ifm.ack goes only to the owner; the non-owner ack is 0
//   - wshb_ifm.dat_sm is broadcast to both slaves
//  Latency: request seen in IDLE -> downstream cyc one clock later. Arbiter adds no latency
//   per beat.
//  beat_cnt:
//   - cleared on entry to MIRE
//   - +1 per mire ack, saturating at MIRE_MAX_BEATS
//   - width $clog2(MIRE_MAX_BEATS+1), min 1
//  last_owner updates on every entry to MIRE or VGA.
//  Owner drops cyc while downstream ack is high in the same cycle: the ack still routes to
//   the owner; the state changes next edge.
//  rst asserted mid-transaction: downstream cyc drops asynchronously. Requesters re-request
//   after reset.
// STRUCTURE
//  wshb_arb_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_MIRE, ARB_VGA} arb_state_t
//   - localparam CTI_CLASSIC=3'b000, CTI_EOB=3'b111
//  Single module, no sub-module: the FSM, beat counter and output mux are one always_ff and
//   one always_comb.
// TESTING
//  1. rst pulse mid mire cycle -> the same cycle shows ifm.cyc=0, grant=00; after release
//     with no requests, grant stays 00.
//  2. mire alone, cyc for 8 classic beats -> grant=01 one clock after cyc.
//     Then 8 acks to mire, 0 to vga, and grant=00 after cyc drops.
//  3. Both cyc rise on one edge, VGA_PRIO=1 -> grant=10.
//     vga drops cyc -> grant=01 on the next edge, no IDLE cycle.
//  4. VGA_PRIO=0, both requesting continuously with single-beat transactions ->
//     grant alternates 01,10,01.
//  5. MIRE_MAX_BEATS=4, mire streams classic beats, vga raises cyc -> grant=10 after
//     mire's 4th ack. Mire holds stb with ack=0 until vga drops cyc, then grant=01.
//  6. Same as 5 but mire uses an incrementing burst (cti=010) of 8 beats ->
//     no preemption until the beat with cti=111.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: arbiter state encoding and Wishbone cycle-type codes
package wshb_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_MIRE, ARB_VGA} arb_state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: registered two-requester Wishbone arbiter sharing the SDRAM master port between mire and vga
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int VGA_PRIO       = 1,
  parameter int MIRE_MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mire_cyc,
  input  logic        i_mire_stb,
  input  logic        i_mire_we,
  input  logic [31:0] i_mire_adr,
  input  logic [3:0]  i_mire_sel,
  input  logic [2:0]  i_mire_cti,
  input  logic [1:0]  i_mire_bte,
  input  logic [31:0] i_mire_dat_ms,
  output logic        o_mire_ack,
  output logic [31:0] o_mire_dat_sm,
  input  logic        i_vga_cyc,
  input  logic        i_vga_stb,
  input  logic        i_vga_we,
  input  logic [31:0] i_vga_adr,
  input  logic [3:0]  i_vga_sel,
  input  logic [2:0]  i_vga_cti,
  input  logic [1:0]  i_vga_bte,
  input  logic [31:0] i_vga_dat_ms,
  output logic        o_vga_ack,
  output logic [31:0] o_vga_dat_sm,
  output logic        o_ifm_cyc,
  output logic        o_ifm_stb,
  output logic        o_ifm_we,
  output logic [31:0] o_ifm_adr,
  output logic [3:0]  o_ifm_sel,
  output logic [2:0]  o_ifm_cti,
  output logic [1:0]  o_ifm_bte,
  output logic [31:0] o_ifm_dat_ms,
  input  logic        i_ifm_ack,
  input  logic [31:0] i_ifm_dat_sm,
  output logic [1:0]  o_grant
);
  localparam int CW = (MIRE_MAX_BEATS > 0) ? $clog2(MIRE_MAX_BEATS + 1) : 1;

  arb_state_t    r_state, w_next;
  logic          r_last_vga;
  logic [CW-1:0] r_beat_cnt;
  logic          w_own_m, w_own_v, w_mire_ack, w_tie_vga, w_preempt;

  always_comb begin
    w_own_m    = r_state == ARB_MIRE;
    w_own_v    = r_state == ARB_VGA;
    w_mire_ack = w_own_m && i_ifm_ack;
    w_tie_vga  = (VGA_PRIO != 0) || !r_last_vga;
    // hand over only on a beat that closes a classic cycle or a burst
    w_preempt  = (MIRE_MAX_BEATS > 0) && w_mire_ack && i_vga_cyc &&
                 (int'(r_beat_cnt) + 1 >= MIRE_MAX_BEATS) &&
                 (i_mire_cti == CTI_CLASSIC || i_mire_cti == CTI_EOB);
    w_next     = (w_own_m && i_mire_cyc) ? (w_preempt ? ARB_VGA : ARB_MIRE) :
                 (w_own_v && i_vga_cyc) ? ARB_VGA :
                 (i_mire_cyc && !w_own_m && i_vga_cyc && !w_own_v) ? (w_tie_vga ? ARB_VGA : ARB_MIRE) :
                 (i_mire_cyc && !w_own_m) ? ARB_MIRE :
                 (i_vga_cyc && !w_own_v) ? ARB_VGA : ARB_IDLE;
    o_grant       = {w_own_v, w_own_m};
    o_ifm_cyc     = w_own_m ? i_mire_cyc    : w_own_v ? i_vga_cyc    : 1'b0;
    o_ifm_stb     = w_own_m ? i_mire_stb    : w_own_v ? i_vga_stb    : 1'b0;
    o_ifm_we      = w_own_m ? i_mire_we     : w_own_v ? i_vga_we     : 1'b0;
    o_ifm_adr     = w_own_m ? i_mire_adr    : w_own_v ? i_vga_adr    : '0;
    o_ifm_sel     = w_own_m ? i_mire_sel    : w_own_v ? i_vga_sel    : '0;
    o_ifm_cti     = w_own_m ? i_mire_cti    : w_own_v ? i_vga_cti    : '0;
    o_ifm_bte     = w_own_m ? i_mire_bte    : w_own_v ? i_vga_bte    : '0;
    o_ifm_dat_ms  = w_own_m ? i_mire_dat_ms : w_own_v ? i_vga_dat_ms : '0;
    o_mire_ack    = w_mire_ack;
    o_vga_ack     = w_own_v && i_ifm_ack;
    o_mire_dat_sm = i_ifm_dat_sm;
    o_vga_dat_sm  = i_ifm_dat_sm;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_last_vga <= 1'b1;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state && w_next != ARB_IDLE) r_last_vga <= w_next == ARB_VGA;
      if (w_next == ARB_MIRE && !w_own_m) r_beat_cnt <= '0;
      else if (w_mire_ack && int'(r_beat_cnt) < MIRE_MAX_BEATS) r_beat_cnt <= r_beat_cnt + CW'(1);
    end
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed scenarios plus randomized traffic against an ownership reference model
module tb_wshb_arbiter;
  localparam int P0_PRIO = 1, P0_MAX = 4, P1_PRIO = 0, P1_MAX = 0;

  logic        clk = 0, rst;
  logic        m_cyc, m_stb, m_we, v_cyc, v_stb, v_we, s_ack;
  logic [31:0] m_adr, m_dat, v_adr, v_dat, s_dat;
  logic [3:0]  m_sel, v_sel;
  logic [2:0]  m_cti, v_cti;
  logic [1:0]  m_bte, v_bte;

  logic [1:0]  grant[2];
  logic        o_cyc[2], o_stb[2], o_we[2], m_ack[2], v_ack[2];
  logic [31:0] o_adr[2], o_dat[2], m_dsm[2], v_dsm[2];
  logic [3:0]  o_sel[2];
  logic [2:0]  o_cti[2];
  logic [1:0]  o_bte[2];
  logic [75:0] m_bus, v_bus, d_bus[2];

  int checks = 0, errors = 0;
  int own[2], last[2], beats[2];

  always #5 clk = ~clk;

  wshb_arbiter #(.VGA_PRIO(P0_PRIO), .MIRE_MAX_BEATS(P0_MAX)) u_p1 (
    .clk(clk), .rst(rst),
    .i_mire_cyc(m_cyc), .i_mire_stb(m_stb), .i_mire_we(m_we), .i_mire_adr(m_adr), .i_mire_sel(m_sel),
    .i_mire_cti(m_cti), .i_mire_bte(m_bte), .i_mire_dat_ms(m_dat), .o_mire_ack(m_ack[0]), .o_mire_dat_sm(m_dsm[0]),
    .i_vga_cyc(v_cyc), .i_vga_stb(v_stb), .i_vga_we(v_we), .i_vga_adr(v_adr), .i_vga_sel(v_sel),
    .i_vga_cti(v_cti), .i_vga_bte(v_bte), .i_vga_dat_ms(v_dat), .o_vga_ack(v_ack[0]), .o_vga_dat_sm(v_dsm[0]),
    .o_ifm_cyc(o_cyc[0]), .o_ifm_stb(o_stb[0]), .o_ifm_we(o_we[0]), .o_ifm_adr(o_adr[0]), .o_ifm_sel(o_sel[0]),
    .o_ifm_cti(o_cti[0]), .o_ifm_bte(o_bte[0]), .o_ifm_dat_ms(o_dat[0]), .i_ifm_ack(s_ack), .i_ifm_dat_sm(s_dat),
    .o_grant(grant[0])
  );

  wshb_arbiter #(.VGA_PRIO(P1_PRIO), .MIRE_MAX_BEATS(P1_MAX)) u_p0 (
    .clk(clk), .rst(rst),
    .i_mire_cyc(m_cyc), .i_mire_stb(m_stb), .i_mire_we(m_we), .i_mire_adr(m_adr), .i_mire_sel(m_sel),
    .i_mire_cti(m_cti), .i_mire_bte(m_bte), .i_mire_dat_ms(m_dat), .o_mire_ack(m_ack[1]), .o_mire_dat_sm(m_dsm[1]),
    .i_vga_cyc(v_cyc), .i_vga_stb(v_stb), .i_vga_we(v_we), .i_vga_adr(v_adr), .i_vga_sel(v_sel),
    .i_vga_cti(v_cti), .i_vga_bte(v_bte), .i_vga_dat_ms(v_dat), .o_vga_ack(v_ack[1]), .o_vga_dat_sm(v_dsm[1]),
    .o_ifm_cyc(o_cyc[1]), .o_ifm_stb(o_stb[1]), .o_ifm_we(o_we[1]), .o_ifm_adr(o_adr[1]), .o_ifm_sel(o_sel[1]),
    .o_ifm_cti(o_cti[1]), .o_ifm_bte(o_bte[1]), .o_ifm_dat_ms(o_dat[1]), .i_ifm_ack(s_ack), .i_ifm_dat_sm(s_dat),
    .o_grant(grant[1])
  );

  assign m_bus    = {m_cyc, m_stb, m_we, m_adr, m_sel, m_cti, m_bte, m_dat};
  assign v_bus    = {v_cyc, v_stb, v_we, v_adr, v_sel, v_cti, v_bte, v_dat};
  assign d_bus[0] = {o_cyc[0], o_stb[0], o_we[0], o_adr[0], o_sel[0], o_cti[0], o_bte[0], o_dat[0]};
  assign d_bus[1] = {o_cyc[1], o_stb[1], o_we[1], o_adr[1], o_sel[1], o_cti[1], o_bte[1], o_dat[1]};

  // Reference owner: 0 none, 1 mire, 2 vga; beats is an unsaturated count of mire acks this grant
  function automatic int next_own(int k);
    int  prio, maxb;
    bit  cm, cv, pre;
    prio = (k == 0) ? P0_PRIO : P1_PRIO;
    maxb = (k == 0) ? P0_MAX : P1_MAX;
    cm   = m_cyc && own[k] != 1;
    cv   = v_cyc && own[k] != 2;
    pre  = own[k] == 1 && maxb > 0 && s_ack && v_cyc && beats[k] + 1 >= maxb &&
           (m_cti == 3'b000 || m_cti == 3'b111);
    if (own[k] == 1 && m_cyc) return pre ? 2 : 1;
    if (own[k] == 2 && v_cyc) return 2;
    if (cm && cv) return (prio != 0 || last[k] == 1) ? 2 : 1;
    return cm ? 1 : cv ? 2 : 0;
  endfunction

  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        own[k] <= 0;
        last[k] <= 2;
        beats[k] <= 0;
      end else begin
        own[k] <= next_own(k);
        if (next_own(k) != own[k] && next_own(k) != 0) last[k] <= next_own(k);
        beats[k] <= (next_own(k) == 1 && own[k] != 1) ? 0 : beats[k] + int'(own[k] == 1 && s_ack);
      end

  task automatic set_idle;
    {m_cyc, m_stb, m_we, m_adr, m_sel, m_cti, m_bte, m_dat} = '0;
    {v_cyc, v_stb, v_we, v_adr, v_sel, v_cti, v_bte, v_dat} = '0;
    s_ack = 0;
    s_dat = 0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic next_sample;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_rst;
    @(negedge clk);
    #1 rst = 1;
    #2 rst = 0;
  endtask

  task automatic test_reset;
    m_cyc = 1; m_stb = 1; s_ack = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (grant[k] !== 2'b00 || o_cyc[k] !== 1'b0 || m_ack[k] !== 1'b0 || d_bus[k] !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: grant=%b cyc=%b ack=%b, want 00/0/0", k, grant[k], o_cyc[k], m_ack[k]);
      end
    end
    #2 rst = 0;
    s_ack = 0;
    next_sample;
    checks++;
    if (grant[0] !== 2'b01) begin
      errors++;
      $display("FAIL reset_regrant: grant=%b want 01", grant[0]);
    end
    #1 rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_cyc[k] !== 1'b0 || grant[k] !== 2'b00) begin
        errors++;
        $display("FAIL reset_async dut%0d: cyc=%b grant=%b, want 0/00", k, o_cyc[k], grant[k]);
      end
    end
    #1 rst = 0;
    m_cyc = 0; m_stb = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (grant[0] !== 2'b00 || grant[1] !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle: grant=%b/%b want 00", grant[0], grant[1]);
      end
    end
  endtask

  task automatic test_mire_alone;
    int na[2], nv[2];
    step;
    m_cyc = 1; m_stb = 1; m_we = 1; m_adr = 32'h100; m_sel = 4'hf; m_dat = 32'hcafe0001;
    @(negedge clk);
    checks++;
    if (grant[0] !== 2'b00) begin
      errors++;
      $display("FAIL mire_latency_early: grant=%b want 00", grant[0]);
    end
    next_sample;
    checks++;
    if (grant[0] !== 2'b01 || o_adr[0] !== 32'h100) begin
      errors++;
      $display("FAIL mire_grant: grant=%b adr=%h want 01/100", grant[0], o_adr[0]);
    end
    step;
    s_ack = 1;
    na = '{0, 0};
    nv = '{0, 0};
    repeat (8) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        na[k] += int'(m_ack[k]);
        nv[k] += int'(v_ack[k]);
      end
      step;
    end
    s_ack = 0; m_cyc = 0; m_stb = 0;
    next_sample;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (na[k] != 8 || nv[k] != 0 || grant[k] !== 2'b00) begin
        errors++;
        $display("FAIL mire_acks dut%0d: mire=%0d vga=%0d grant=%b, want 8/0/00", k, na[k], nv[k], grant[k]);
      end
    end
  endtask

  task automatic test_vga_prio;
    step;
    m_cyc = 1; m_stb = 1; v_cyc = 1; v_stb = 1; v_adr = 32'h200;
    next_sample;
    checks++;
    if (grant[0] !== 2'b10 || o_adr[0] !== 32'h200) begin
      errors++;
      $display("FAIL vga_prio: grant=%b adr=%h want 10/200", grant[0], o_adr[0]);
    end
    #1 v_cyc = 0; v_stb = 0;
    next_sample;
    checks++;
    if (grant[0] !== 2'b01) begin
      errors++;
      $display("FAIL vga_handover: grant=%b want 01", grant[0]);
    end
    #1 m_cyc = 0; m_stb = 0;
    next_sample;
    checks++;
    if (grant[0] !== 2'b00 || grant[1] !== 2'b00) begin
      errors++;
      $display("FAIL vga_prio_idle: grant=%b/%b want 00", grant[0], grant[1]);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] g, first, prev;
    logic       ma, va;
    int         changes, idles;
    set_idle;
    pulse_rst;
    m_cyc = 1; m_stb = 1; v_cyc = 1; v_stb = 1; s_ack = 1;
    changes = 0; idles = 0; first = 2'b00; prev = 2'b00;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g = grant[1];
      if (i == 0) first = g;
      else if (g != prev) changes++;
      if (g == 2'b00) idles++;
      prev = g;
      ma = m_ack[1];
      va = v_ack[1];
      step;
      m_cyc = !ma; m_stb = !ma; v_cyc = !va; v_stb = !va;
    end
    checks++;
    if (first !== 2'b01) begin
      errors++;
      $display("FAIL rr_first: grant=%b want 01", first);
    end
    checks++;
    if (idles != 0 || changes < 3) begin
      errors++;
      $display("FAIL rr_alternate: idle_cycles=%0d changes=%0d, want 0 and >=3", idles, changes);
    end
    set_idle;
  endtask

  task automatic test_preempt;
    int n, bad;
    bit hit;
    set_idle;
    pulse_rst;
    m_cyc = 1; m_stb = 1; m_cti = 3'b000; s_ack = 1;
    n = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (grant[0] === 2'b10) hit = 1;
      else begin
        n += int'(m_ack[0]);
        step;
        v_cyc = 1; v_stb = 1;
      end
    end
    checks++;
    if (!hit || n != 4) begin
      errors++;
      $display("FAIL preempt_point: switched=%0d mire_acks=%0d, want 1/4", hit, n);
    end
    bad = 0;
    repeat (3) begin
      if (m_ack[0] !== 1'b0 || grant[0] !== 2'b10 || v_ack[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL preempt_hold: bad_cycles=%0d want 0", bad);
    end
    #1 v_cyc = 0; v_stb = 0;
    next_sample;
    checks++;
    if (grant[0] !== 2'b01 || m_ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL preempt_regrant: grant=%b ack=%b want 01/1", grant[0], m_ack[0]);
    end
    set_idle;
  endtask

  task automatic test_burst;
    int n;
    bit hit;
    set_idle;
    pulse_rst;
    m_cyc = 1; m_stb = 1; m_cti = 3'b010; s_ack = 1;
    n = 0; hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (grant[0] === 2'b10) hit = 1;
      else begin
        n += int'(m_ack[0]);
        step;
        v_cyc = 1; v_stb = 1;
        m_cti = (n == 7) ? 3'b111 : 3'b010;
      end
    end
    checks++;
    if (!hit || n != 8) begin
      errors++;
      $display("FAIL burst_preempt: switched=%0d mire_acks=%0d, want 1/8", hit, n);
    end
    #1 set_idle;
    next_sample;
    checks++;
    if (grant[0] !== 2'b00) begin
      errors++;
      $display("FAIL burst_idle: grant=%b want 00", grant[0]);
    end
  endtask

  task automatic test_random;
    logic [1:0]  eg;
    logic [75:0] eb;
    set_idle;
    pulse_rst;
    repeat (3000) begin
      step;
      if ($urandom_range(5) == 0) m_cyc = !m_cyc;
      if ($urandom_range(5) == 0) v_cyc = !v_cyc;
      m_stb = m_cyc; v_stb = v_cyc;
      m_we = 1'($urandom_range(1)); v_we = 1'($urandom_range(1));
      m_adr = $urandom; v_adr = $urandom; m_dat = $urandom; v_dat = $urandom;
      m_sel = 4'($urandom); v_sel = 4'($urandom); m_bte = 2'($urandom); v_bte = 2'($urandom);
      m_cti = ($urandom_range(2) == 0) ? 3'b010 : ($urandom_range(1) == 1 ? 3'b111 : 3'b000);
      v_cti = 3'($urandom);
      s_ack = 1'($urandom_range(1));
      s_dat = $urandom;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        eg = own[k] == 1 ? 2'b01 : own[k] == 2 ? 2'b10 : 2'b00;
        eb = own[k] == 1 ? m_bus : own[k] == 2 ? v_bus : '0;
        checks++;
        if (grant[k] !== eg) begin
          errors++;
          $display("FAIL rand_grant dut%0d: got %b want %b", k, grant[k], eg);
        end
        checks++;
        if (d_bus[k] !== eb) begin
          errors++;
          $display("FAIL rand_bus dut%0d: got %h want %h", k, d_bus[k], eb);
        end
        checks++;
        if (m_ack[k] !== (own[k] == 1 && s_ack) || v_ack[k] !== (own[k] == 2 && s_ack)) begin
          errors++;
          $display("FAIL rand_ack dut%0d: got m=%b v=%b want m=%b v=%b", k, m_ack[k], v_ack[k],
                   own[k] == 1 && s_ack, own[k] == 2 && s_ack);
        end
        checks++;
        if (m_dsm[k] !== s_dat || v_dsm[k] !== s_dat) begin
          errors++;
          $display("FAIL rand_dat_sm dut%0d: got %h/%h want %h", k, m_dsm[k], v_dsm[k], s_dat);
        end
      end
    end
    set_idle;
  endtask

  initial begin
    rst = 1;
    set_idle;
    test_reset;
    test_mire_alone;
    test_vga_prio;
    test_round_robin;
    test_preempt;
    test_burst;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
